// File: rtl/uart_rx_mmio_if.sv
// Bus bundle for the UART receive MMIO bridge: UART capture side plus the load-path read port.
// The master drives the UART byte and the load strobe; the slave (the bridge) returns read data and the IRQ.
interface uart_rx_mmio_if;
    logic        rx_done_flag;
    logic [7:0]  rx_data;
    logic [2:0]  error_flag;
    logic        re;
    logic        reg_sel;
    logic [31:0] rd_data;
    logic        rx_irq;

    modport master (
        output rx_done_flag,
        output rx_data,
        output error_flag,
        output re,
        output reg_sel,
        input  rd_data,
        input  rx_irq
    );

    modport slave (
        input  rx_done_flag,
        input  rx_data,
        input  error_flag,
        input  re,
        input  reg_sel,
        output rd_data,
        output rx_irq
    );
endinterface

// File: rtl/uart_rx_mmio.sv
// Receive-side MMIO bridge: buffers UART bytes in a FIFO and exposes DATA (pop) and
// STATUS (level + read-to-clear sticky errors) registers to the load path.
module uart_rx_mmio #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input logic           clk,
    input logic           reset,
    uart_rx_mmio_if.slave bus
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [7:0]    count8;
    logic          prev_done;
    logic          overflow;
    logic [2:0]    err_sticky;

    logic          push_evt;
    logic          err_evt;
    logic          push_ok;
    logic          ovf_evt;
    logic          pop;
    logic          stat_rd;
    logic          full;
    logic          empty;
    logic [31:0]   status_word;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push when read.
    always_comb begin
        push_evt   = bus.rx_done_flag & ~prev_done;
        full       = (count == (AW+1)'(DEPTH));
        empty      = (count == '0);
        pop        = bus.re & ~bus.reg_sel & ~empty;
        stat_rd    = bus.re & bus.reg_sel;
        err_evt    = push_evt & (bus.error_flag != 3'b000);
        push_ok    = push_evt & ~err_evt & (~full | pop);
        ovf_evt    = push_evt & ~err_evt & full & ~pop;
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
        count8      = 8'(count);
        status_word = {16'b0, count8, 2'b00, err_sticky, overflow, full, ~empty};
    end

    // Storage is not reset; clearing the pointers and count is enough to discard contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.rx_data;
        end
    end

    // A STATUS read clears the sticky bits, but a new event in the same cycle re-sets them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            prev_done   <= 1'b0;
            overflow    <= 1'b0;
            err_sticky  <= 3'b000;
            bus.rd_data <= 32'h0000_0000;
            bus.rx_irq  <= 1'b0;
        end else begin
            prev_done <= bus.rx_done_flag;
            count     <= count_next;
            bus.rx_irq <= (count_next != '0);

            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (stat_rd) begin
                overflow   <= ovf_evt;
                err_sticky <= err_evt ? bus.error_flag : 3'b000;
            end else begin
                overflow   <= overflow | ovf_evt;
                err_sticky <= err_sticky | (err_evt ? bus.error_flag : 3'b000);
            end

            if (bus.re) begin
                if (bus.reg_sel) begin
                    bus.rd_data <= status_word;
                end else if (!empty) begin
                    bus.rd_data <= {24'b0, mem[rd_ptr]};
                end else begin
                    bus.rd_data <= 32'h0000_0000;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Scoreboard bench for uart_rx_mmio: reads push their expected word into a queue and a
// separate monitor pops and compares it the cycle after each load strobe.
module tb_uart_rx_mmio;

    logic clk;
    logic reset;
    int   num_checks;
    int   num_fail;
    logic [31:0] exp_q [$];

    uart_rx_mmio_if bus();

    uart_rx_mmio #(.DEPTH(8), .AW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One cycle of inputs; if a read is issued its expected result goes to the scoreboard.
    task automatic applyStimulus(input logic done, input logic [7:0] data, input logic [2:0] err,
                                 input logic rd, input logic sel, input logic [31:0] exp);
        bus.rx_done_flag = done;
        bus.rx_data      = data;
        bus.error_flag   = err;
        bus.re           = rd;
        bus.reg_sel      = sel;
        if (rd) exp_q.push_back(exp);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic pushByte(input logic [7:0] data, input logic [2:0] err);
        applyStimulus(1'b1, data, err, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic readData(input logic [31:0] exp);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, exp);
    endtask

    task automatic readStatus(input logic [31:0] exp);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b1, exp);
    endtask

    // Monitor: a strobe seen at a rising edge means rd_data is checked on the following falling edge.
    initial begin : monitor
        logic pend;
        forever begin
            @(posedge clk);
            pend = bus.re & ~reset;
            @(negedge clk);
            if (pend) begin
                if (exp_q.size() == 0) begin
                    num_checks++;
                    num_fail++;
                    $display("[TB] FAIL scoreboard: read with no expected value, got 0x%08h", bus.rd_data);
                end else begin
                    checkOutput("rd_data", bus.rd_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        num_checks       = 0;
        num_fail         = 0;
        reset            = 1'b1;
        bus.rx_done_flag = 1'b0;
        bus.rx_data      = 8'h00;
        bus.error_flag   = 3'b000;
        bus.re           = 1'b0;
        bus.reg_sel      = 1'b0;
        @(negedge clk);

        $display("[TB] reset behaviour");
        pushByte(8'h11, 3'b000);
        pushByte(8'h22, 3'b000);
        checkOutput("reset rd_data", bus.rd_data, 32'h0);
        checkOutput("reset rx_irq", {31'b0, bus.rx_irq}, 32'h0);
        reset = 1'b0;
        idle(1);
        readStatus(32'h0000_0000);

        $display("[TB] single byte");
        pushByte(8'hA5, 3'b000);
        checkOutput("single rx_irq set", {31'b0, bus.rx_irq}, 32'h1);
        readData(32'h0000_00A5);
        checkOutput("single rx_irq clear", {31'b0, bus.rx_irq}, 32'h0);
        readStatus(32'h0000_0000);

        $display("[TB] fill and overflow");
        for (int i = 1; i <= 9; i++) pushByte(8'(i), 3'b000);
        readStatus(32'h0000_0807);
        readStatus(32'h0000_0803);
        for (int i = 1; i <= 8; i++) readData(32'(i));
        checkOutput("fill rx_irq drained", {31'b0, bus.rx_irq}, 32'h0);
        readData(32'h0000_0000);
        readStatus(32'h0000_0000);

        $display("[TB] error drop");
        pushByte(8'h55, 3'b001);
        checkOutput("error rx_irq", {31'b0, bus.rx_irq}, 32'h0);
        readStatus(32'h0000_0008);
        readStatus(32'h0000_0000);

        $display("[TB] simultaneous push and pop");
        for (int i = 0; i < 8; i++) pushByte(8'h10 + 8'(i), 3'b000);
        applyStimulus(1'b1, 8'h77, 3'b000, 1'b1, 1'b0, 32'h0000_0010);
        idle(1);
        readStatus(32'h0000_0803);
        for (int i = 1; i < 8; i++) readData(32'h10 + 32'(i));
        readData(32'h0000_0077);
        readStatus(32'h0000_0000);

        $display("[TB] sticky set during status clear");
        applyStimulus(1'b1, 8'hEE, 3'b100, 1'b1, 1'b1, 32'h0000_0000);
        idle(1);
        readStatus(32'h0000_0020);
        readStatus(32'h0000_0000);

        $display("[TB] empty push with data read");
        applyStimulus(1'b1, 8'h3C, 3'b000, 1'b1, 1'b0, 32'h0000_0000);
        idle(1);
        checkOutput("empty-push rx_irq", {31'b0, bus.rx_irq}, 32'h1);
        readStatus(32'h0000_0101);
        readData(32'h0000_003C);

        $display("[TB] held-high done flag");
        repeat (5) applyStimulus(1'b1, 8'h5A, 3'b000, 1'b0, 1'b0, 32'h0);
        idle(1);
        readStatus(32'h0000_0101);
        readData(32'h0000_005A);
        readStatus(32'h0000_0000);

        $display("[TB] pointer wrap");
        for (int i = 0; i < 20; i++) begin
            pushByte(8'h30 + 8'(i), 3'b000);
            readData(32'h30 + 32'(i));
        end

        $display("[TB] reset mid-stream");
        pushByte(8'h61, 3'b000);
        pushByte(8'h62, 3'b000);
        pushByte(8'h63, 3'b000);
        checkOutput("prereset rx_irq", {31'b0, bus.rx_irq}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset rd_data", bus.rd_data, 32'h0);
        checkOutput("midreset rx_irq", {31'b0, bus.rx_irq}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        readStatus(32'h0000_0000);
        readData(32'h0000_0000);

        idle(3);
        num_checks++;
        if (exp_q.size() != 0) begin
            num_fail++;
            $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
